pwm_multi: RTL and testbench

- N-channel PWM generator with signed 2's-complement duty per channel, producing a magnitude-proportional `out` and a sign `dir` for each channel.
- All channels share one period counter. Duty values are double-buffered, written through a channel-addressed port, and committed only at period end.
- Adds a runtime-selectable edge- or centre-aligned mode, a sticky brake, and a period-boundary strobe.
- Sits between the control-law/register interface and the H-bridge drivers.

---
 rtl/pwm_pkg.sv | 26 ++
 rtl/pwm_multi_if.sv | 18 +
 rtl/pwm_chan_cmp.sv | 72 +++++++
 rtl/pwm_multi.sv | 110 +++++++++++
 tb/tb_pwm_multi.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Brief    : Shared mode encodings, count-direction type and duty magnitude helper
// Revision : 1.0 - initial release
// ============================================================================
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTRE = 1'b1;

  typedef enum logic [0:0] {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Caller sign-extends its duty to 32 bits and truncates the result back to
  // its own width; the most negative duty then maps onto 2**(W-1).
  function automatic logic [31:0] magn_of(input logic signed [31:0] duty);
    logic [31:0] u;
    u = duty;
    return u[31] ? (~u + 32'd1) : u;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : pwm_multi_if
// Brief    : Channel-addressed shadow duty write port
// Revision : 1.0 - initial release
// ============================================================================
interface pwm_multi_if #(
  parameter int CH_SEL_W = 2,
  parameter int W        = 10
);
  logic                wr_en;
  logic [CH_SEL_W-1:0] wr_ch;
  logic [W-1:0]        wr_data;

  modport master (output wr_en, output wr_ch, output wr_data);
  modport slave  (input  wr_en, input  wr_ch, input  wr_data);
endinterface
`default_nettype wire

// File: rtl/pwm_chan_cmp.sv
`default_nettype none
// ============================================================================
// Module   : pwm_chan_cmp
// Brief    : One PWM channel: shadow/active duty, magnitude compare, out/dir flops
// Revision : 1.0 - initial release
// ============================================================================
module pwm_chan_cmp
  import pwm_pkg::*;
#(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         ce,
  input  logic         oe,
  input  logic         brake_kill,
  input  logic [W-2:0] count,
  input  logic         commit,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic         out,
  output logic         dir
);

  logic [W-1:0] shadow_q, shadow_d;
  logic [W-1:0] magn_q,   magn_d;
  logic         sign_q,   sign_d;
  logic         out_q,    out_d;
  logic         dir_q,    dir_d;
  logic [W-1:0] commit_src;

  always_comb begin
    // A write landing on the commit cycle bypasses straight into the active set
    commit_src = wr_en ? wr_data : shadow_q;
    shadow_d   = commit_src;
    magn_d     = magn_q;
    sign_d     = sign_q;
    if (commit) begin
      magn_d = W'(magn_of(32'($signed(commit_src))));
      sign_d = commit_src[W-1];
    end

    out_d = out_q;
    dir_d = dir_q;
    if (ce) begin
      out_d = oe && ({1'b0, count} < magn_q);
      dir_d = sign_q;
    end
    if (brake_kill) out_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= '0;
      magn_q   <= '0;
      sign_q   <= 1'b0;
      out_q    <= 1'b0;
      dir_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      magn_q   <= magn_d;
      sign_q   <= sign_d;
      out_q    <= out_d;
      dir_q    <= dir_d;
    end
  end

  assign out = out_q;
  assign dir = dir_q;

endmodule
`default_nettype wire

// File: rtl/pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : pwm_multi
// Brief    : N-channel signed PWM with shared edge/centre counter, brake, strobe
// Revision : 1.0 - initial release
// ============================================================================
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int PWM_IN_SIZE = 10,
  parameter int NUM_CH      = 4,
  parameter int CH_SEL_W    = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce,
  input  logic              oe,
  input  logic              mode,
  pwm_multi_if.slave        wr_if,
  input  logic              brake,
  input  logic              brake_clr,
  output logic [NUM_CH-1:0] out,
  output logic [NUM_CH-1:0] dir,
  output logic              period_strobe,
  output logic              brake_active
);

  localparam int              CNT_W   = PWM_IN_SIZE - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;
  dir_e             cdir_q,  cdir_d;
  logic             mode_q,  mode_d;
  logic             strobe_q;
  logic             brake_q, brake_d;
  logic             period_end;

  always_comb begin
    count_d    = count_q;
    cdir_d     = cdir_q;
    mode_d     = mode_q;
    period_end = 1'b0;
    if (ce) begin
      if (mode_q == MODE_EDGE) period_end = (count_q == CNT_MAX);
      else                     period_end = (cdir_q == DIR_DOWN) && (count_q == CNT_ONE);

      // Every period, and every mode change, restarts from zero counting up
      if (period_end) begin
        count_d = '0;
        cdir_d  = DIR_UP;
        mode_d  = mode;
      end else if (mode_q == MODE_EDGE) begin
        count_d = count_q + CNT_ONE;
      end else if (cdir_q == DIR_UP) begin
        if (count_q == CNT_MAX) begin
          count_d = count_q - CNT_ONE;
          cdir_d  = DIR_DOWN;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end else begin
        count_d = count_q - CNT_ONE;
      end
    end

    if (brake)          brake_d = 1'b1;
    else if (brake_clr) brake_d = 1'b0;
    else                brake_d = brake_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      cdir_q   <= DIR_UP;
      mode_q   <= MODE_EDGE;
      strobe_q <= 1'b0;
      brake_q  <= 1'b0;
    end else begin
      count_q  <= count_d;
      cdir_q   <= cdir_d;
      mode_q   <= mode_d;
      strobe_q <= period_end;
      brake_q  <= brake_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    pwm_chan_cmp #(
      .W (PWM_IN_SIZE)
    ) u_chan (
      .clk        (clk),
      .reset_n    (reset_n),
      .ce         (ce),
      .oe         (oe),
      .brake_kill (brake | brake_q),
      .count      (count_q),
      .commit     (period_end),
      .wr_en      (wr_if.wr_en && (wr_if.wr_ch == CH_SEL_W'(k))),
      .wr_data    (wr_if.wr_data),
      .out        (out[k]),
      .dir        (dir[k])
    );
  end

  assign period_strobe = strobe_q;
  assign brake_active  = brake_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_multi
// Brief    : Scoreboard bench for pwm_multi (W=4, two channels)
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_multi;

  localparam int W   = 4;
  localparam int NCH = 2;
  localparam int CSW = 2;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           ce = 1'b0, oe = 1'b0, mode = 1'b0;
  logic           brake = 1'b0, brake_clr = 1'b0;
  logic [NCH-1:0] out, dir;
  logic           period_strobe, brake_active;

  pwm_multi_if #(.CH_SEL_W(CSW), .W(W)) wr_if ();

  always #5 clk = ~clk;

  pwm_multi #(
    .PWM_IN_SIZE (W),
    .NUM_CH      (NCH),
    .CH_SEL_W    (CSW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ce            (ce),
    .oe            (oe),
    .mode          (mode),
    .wr_if         (wr_if),
    .brake         (brake),
    .brake_clr     (brake_clr),
    .out           (out),
    .dir           (dir),
    .period_strobe (period_strobe),
    .brake_active  (brake_active)
  );

  typedef struct packed {
    logic [NCH-1:0] out;
    logic [NCH-1:0] dir;
    logic           strobe;
    logic           brk;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Model: period phase p; count derived from phase and mode
  int             p;
  bit             m_mode;
  int             m_shadow [NCH];
  int             m_amag   [NCH];
  bit             m_asign  [NCH];
  bit             m_brk;
  logic [NCH-1:0] m_out, m_dir;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mcnt();
    if (!m_mode) return p;
    return (p < 8) ? p : 14 - p;
  endfunction

  task automatic model_reset();
    p = 0; m_mode = 1'b0; m_brk = 1'b0; m_out = '0; m_dir = '0;
    for (int c = 0; c < NCH; c++) begin
      m_shadow[c] = 0; m_amag[c] = 0; m_asign[c] = 1'b0;
    end
  endtask

  task automatic step();
    exp_t e;
    bit   pe, wsel;
    int   wv, src;
    pe = ce && (m_mode ? (p == 13) : (p == 7));
    wv = $signed(wr_if.wr_data);
    for (int c = 0; c < NCH; c++) begin
      if (brake || m_brk) m_out[c] = 1'b0;
      else if (ce)        m_out[c] = oe && (mcnt() < m_amag[c]);
      if (ce) m_dir[c] = m_asign[c];
      wsel = wr_if.wr_en && (int'(wr_if.wr_ch) == c);
      if (pe) begin
        src = wsel ? wv : m_shadow[c];
        m_amag[c]  = (src < 0) ? -src : src;
        m_asign[c] = (src < 0);
      end
      if (wsel) m_shadow[c] = wv;
    end
    if (ce) begin
      if (pe) begin p = 0; m_mode = mode; end
      else p++;
    end
    if (brake)          m_brk = 1'b1;
    else if (brake_clr) m_brk = 1'b0;
    e.out = m_out; e.dir = m_dir; e.strobe = pe; e.brk = m_brk;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    check_val("out",    32'(out),           32'(e.out));
    check_val("dir",    32'(dir),           32'(e.dir));
    check_val("strobe", 32'(period_strobe), 32'(e.strobe));
    check_val("brake",  32'(brake_active),  32'(e.brk));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to_cnt(input int v);
    int n = 0;
    while (mcnt() != v && n < 40) begin step(); n++; end
  endtask

  task automatic wr(input int ch, input int val);
    wr_if.wr_en = 1'b1; wr_if.wr_ch = CSW'(ch); wr_if.wr_data = W'(val);
    step();
    wr_if.wr_en = 1'b0;
  endtask

  initial begin
    wr_if.wr_en = 1'b0; wr_if.wr_ch = '0; wr_if.wr_data = '0;
    model_reset();
    ce = 1'b1; oe = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_out",    32'(out),           32'd0);
    check_val("rst_dir",    32'(dir),           32'd0);
    check_val("rst_strobe", 32'(period_strobe), 32'd0);
    check_val("rst_brake",  32'(brake_active),  32'd0);
    reset_n = 1'b1;

    // Edge mode: +3 and full-scale negative
    wr(0, 3); wr(1, -8); run(20);
    // Negative duty, mid-period write, write on the commit cycle
    wr(0, -3); run(16);
    run_to_cnt(4); wr(0, 5); run(16);
    run_to_cnt(7); wr(0, 2); run(10);
    // Edge -> centre switch requested mid-period
    wr(0, 3); mode = 1'b1;
    run_to_cnt(3); run(40);
    // Back to edge, brake sequence
    mode = 1'b0; wr(0, 7); run(30);
    run_to_cnt(1); brake = 1'b1; step(); brake = 1'b0;
    run(5);
    ce = 1'b0; run(3); ce = 1'b1;
    brake_clr = 1'b1; step(); brake_clr = 1'b0;
    run(10);
    // ce hold without brake
    ce = 1'b0; run(3); ce = 1'b1; run(4);
    // Out-of-range channel writes are ignored
    wr(2, 5); wr(3, 1); run(12);
    // Output enable
    oe = 1'b0; run(4); oe = 1'b1; run(4);
    // brake wins over brake_clr
    brake = 1'b1; brake_clr = 1'b1; step(); brake = 1'b0; step();
    brake_clr = 1'b0; run(8);

    // Asynchronous reset mid-period
    run_to_cnt(3);
    #2 reset_n = 1'b0;
    #1;
    check_val("arst_out",    32'(out),           32'd0);
    check_val("arst_dir",    32'(dir),           32'd0);
    check_val("arst_strobe", 32'(period_strobe), 32'd0);
    check_val("arst_brake",  32'(brake_active),  32'd0);
    sb.delete();
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    run(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
